// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - RV32I field encoder feeding a word FIFO that loads instruction memory
module inst_encoder_loader #(
   parameter int                ADDR_W     = 11,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_vld,
   output logic              o_req_rdy,
   input  logic [2:0]        i_fmt,
   input  logic [6:0]        i_opcode,
   input  logic [4:0]        i_rd,
   input  logic [4:0]        i_rs1,
   input  logic [4:0]        i_rs2,
   input  logic [2:0]        i_funct3,
   input  logic [6:0]        i_funct7,
   input  logic [31:0]       i_imm,
   input  logic              i_flush,
   output logic              o_mem_wren,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   input  logic              i_mem_ack,
   output logic [ADDR_W:0]   o_count,
   output logic              o_err
);

   localparam int IDX_W = $clog2(FIFO_DEPTH);
   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;
   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic [31:0]  fifo_mem [FIFO_DEPTH];
   logic [IDX_W:0] wr_ptr;
   logic [IDX_W:0] rd_ptr;
   logic         fifo_empty;
   logic         fifo_full;
   logic [31:0]  enc_word;
   logic         req_valid;
   logic         accept;
   logic         push;
   logic         pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   assign o_req_rdy   = !fifo_full;
   assign o_mem_wren  = !fifo_empty;
   assign o_mem_wdata = fifo_empty ? 32'd0 : fifo_mem[rd_ptr[IDX_W-1:0]];

   // Flush overrides both sides; an invalid request is consumed but never pushed.
   assign accept = i_req_vld && o_req_rdy && !i_flush;
   assign push   = accept && req_valid;
   assign pop    = i_mem_ack && !fifo_empty && !i_flush;

   // Pack the fields by format; odd branch/jump offsets and unknown formats are invalid.
   always_comb begin
      enc_word  = 32'd0;
      req_valid = 1'b1;
      case (i_fmt)
         FMT_R: enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
         FMT_I: enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
         FMT_S: enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
         FMT_B: begin
            enc_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                         i_imm[4:1], i_imm[11], i_opcode};
            req_valid = !i_imm[0];
         end
         FMT_U: enc_word = {i_imm[31:12], i_rd, i_opcode};
         FMT_J: begin
            enc_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            req_valid = !i_imm[0];
         end
         default: req_valid = 1'b0;
      endcase
   end

   // Buffer storage needs no reset; the read mux masks stale entries while empty.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr[IDX_W-1:0]] <= enc_word;
      end
   end

   // FIFO pointers: push and pop proceed independently, flush empties.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (IDX_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (IDX_W+1)'(1);
      end
   end

   // Write address wraps, write count saturates, both advance only on a real ack.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_mem_addr <= BASE_ADDR;
         o_count    <= '0;
      end else if (i_flush) begin
         o_mem_addr <= BASE_ADDR;
         o_count    <= '0;
      end else if (pop) begin
         o_mem_addr <= o_mem_addr + ADDR_W'(1);
         if (o_count != CNT_MAX) o_count <= o_count + (ADDR_W+1)'(1);
      end
   end

   // Sticky error for a dropped request, cleared only by flush or reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_err <= 1'b0;
      end else if (i_flush) begin
         o_err <= 1'b0;
      end else if (accept && !req_valid) begin
         o_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - self-checking bench for inst_encoder_loader
module tb_inst_encoder_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_vld;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        flush;
   logic        mem_ack;

   logic        a_rdy, a_wren, a_err;
   logic [10:0] a_addr;
   logic [31:0] a_wdata;
   logic [11:0] a_count;
   logic        b_rdy, b_wren, b_err;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] mq[$];
   int          n_wr;
   bit          m_err;
   bit          last_accept;
   logic [31:0] cur_exp;

   always #5 clk = ~clk;

   inst_encoder_loader u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .o_req_rdy(a_rdy),
      .i_fmt(fmt), .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
      .i_funct3(funct3), .i_funct7(funct7), .i_imm(imm), .i_flush(flush),
      .o_mem_wren(a_wren), .o_mem_addr(a_addr), .o_mem_wdata(a_wdata),
      .i_mem_ack(mem_ack), .o_count(a_count), .o_err(a_err)
   );

   inst_encoder_loader #(.ADDR_W(2)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .o_req_rdy(b_rdy),
      .i_fmt(fmt), .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
      .i_funct3(funct3), .i_funct7(funct7), .i_imm(imm), .i_flush(flush),
      .o_mem_wren(b_wren), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata),
      .i_mem_ack(mem_ack), .o_count(b_count), .o_err(b_err)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Reference encoding built from field weights with shifts and masks.
   function automatic logic [31:0] model_enc(input int f, input logic [31:0] op,
      input logic [31:0] d, input logic [31:0] s1, input logic [31:0] s2,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] im);
      logic [31:0] common;
      common = (s1 << 15) | (f3 << 12) | op;
      case (f)
         0: return (f7 << 25) | (s2 << 20) | common | (d << 7);
         1: return ((im & 32'hFFF) << 20) | common | (d << 7);
         2: return (((im >> 5) & 32'h7F) << 25) | (s2 << 20) | common | ((im & 32'h1F) << 7);
         3: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (s2 << 20) |
                   common | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
         4: return (im & 32'hFFFFF000) | (d << 7) | op;
         5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
                   (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | (d << 7) | op;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit is_valid(input int f, input logic [31:0] im);
      if (f > 5) return 1'b0;
      if ((f == 3 || f == 5) && im[0]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int sz = mq.size();
      check("a_rdy",   32'(a_rdy),   32'(sz < 4));
      check("b_rdy",   32'(b_rdy),   32'(sz < 4));
      check("a_wren",  32'(a_wren),  32'(sz > 0));
      check("b_wren",  32'(b_wren),  32'(sz > 0));
      check("a_addr",  32'(a_addr),  32'(n_wr % 2048));
      check("b_addr",  32'(b_addr),  32'(n_wr % 4));
      check("a_count", 32'(a_count), 32'((n_wr < 2048) ? n_wr : 2048));
      check("b_count", 32'(b_count), 32'((n_wr < 4) ? n_wr : 4));
      check("a_err",   32'(a_err),   32'(m_err));
      check("b_err",   32'(b_err),   32'(m_err));
      if (sz > 0) begin
         check("a_wdata", a_wdata, mq[0]);
         check("b_wdata", b_wdata, mq[0]);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      n_wr  = 0;
      m_err = 1'b0;
   endtask

   // One cycle: compare, take the edge, then apply that edge's effect to the model.
   task automatic tick();
      bit rdy_m;
      check_outputs();
      @(posedge clk);
      rdy_m       = (mq.size() < 4);
      last_accept = 1'b0;
      if (flush) begin
         model_reset();
      end else begin
         if (mem_ack && mq.size() > 0) begin
            void'(mq.pop_front());
            n_wr++;
         end
         if (req_vld && rdy_m) begin
            last_accept = 1'b1;
            if (is_valid(int'(fmt), imm)) mq.push_back(cur_exp);
            else m_err = 1'b1;
         end
      end
      #1;
   endtask

   task automatic set_req(input int f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im, input logic [31:0] exp);
      req_vld = 1'b1;
      fmt     = 3'(f);
      opcode  = op;
      rd      = d;
      rs1     = s1;
      rs2     = s2;
      funct3  = f3;
      funct7  = f7;
      imm     = im;
      cur_exp = exp;
   endtask

   task automatic set_rand_req(input int f, input bit force_even);
      logic [6:0]  op = 7'($urandom);
      logic [4:0]  d  = 5'($urandom);
      logic [4:0]  s1 = 5'($urandom);
      logic [4:0]  s2 = 5'($urandom);
      logic [2:0]  f3 = 3'($urandom);
      logic [6:0]  f7 = 7'($urandom);
      logic [31:0] im = $urandom;
      if (force_even) im[0] = 1'b0;
      set_req(f, op, d, s1, s2, f3, f7, im,
              model_enc(f, 32'(op), 32'(d), 32'(s1), 32'(s2), 32'(f3), 32'(f7), im));
   endtask

   initial begin
      rst_n = 1'b0; req_vld = 1'b0; flush = 1'b0; mem_ack = 1'b0;
      fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
      funct3 = '0; funct7 = '0; imm = '0; cur_exp = '0;
      model_reset();
      last_accept = 1'b0;
      #2;
      check_outputs();
      check("a_wdata_rst", a_wdata, 32'd0);
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      // Each format with ack held high, known encodings.
      mem_ack = 1'b1;
      set_req(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h00500093); tick();
      set_req(0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,          32'h002081B3); tick();
      set_req(2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020A423); tick();
      set_req(3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC,   32'hFE000EE3); tick();
      set_req(4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,   32'h123452B7); tick();
      set_req(5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,          32'h008000EF); tick();
      req_vld = 1'b0;
      repeat (3) tick();
      check("a_count_six", 32'(a_count), 32'd6);
      check("b_count_sat", 32'(b_count), 32'd4);

      // Backpressure: five offers with ack low, fifth held until space appears.
      flush = 1'b1; tick(); flush = 1'b0;
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_rand_req(0, 1'b0);
         tick();
      end
      set_rand_req(1, 1'b0);
      repeat (3) tick();
      mem_ack = 1'b1;
      for (int i = 0; i < 10 && !last_accept; i++) tick();
      check("fifth_accepted", 32'(last_accept), 32'd1);
      req_vld = 1'b0;
      repeat (6) tick();

      // Invalid requests then a valid one.
      set_rand_req(7, 1'b0); tick();
      req_vld = 1'b0; tick();
      set_rand_req(3, 1'b0); imm = 32'd3; tick();
      req_vld = 1'b0; tick();
      set_rand_req(2, 1'b0); tick();
      req_vld = 1'b0; repeat (3) tick();

      // Flush with three words queued while ack and a request coincide.
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_rand_req(i, 1'b1);
         tick();
      end
      mem_ack = 1'b1; flush = 1'b1; set_rand_req(4, 1'b0);
      tick();
      flush = 1'b0; req_vld = 1'b0;
      tick();

      // Randomized traffic including wrap, saturation and occasional flush.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 1) set_rand_req(int'($urandom_range(0, 7)), 1'b0);
         else req_vld = 1'b0;
         mem_ack = ($urandom_range(0, 9) < 7);
         flush   = ($urandom_range(0, 59) == 0);
         tick();
      end
      flush = 1'b0;

      // Asynchronous reset in the middle of a stalled write.
      flush = 1'b1; req_vld = 1'b0; tick(); flush = 1'b0;
      mem_ack = 1'b0;
      set_rand_req(1, 1'b0); tick();
      req_vld = 1'b0;
      check("wren_before_rst", 32'(a_wren), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      check("a_wdata_async_rst", a_wdata, 32'd0);
      check("b_wdata_async_rst", b_wdata, 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
